// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 pixel-timing generator.
// Divides clk to the pixel rate, runs the pixel/line counters and produces
// sync, active-video and line/frame strobes. All the decoded outputs are
// registered from the next-state counter values, so they line up with the
// hcount/vcount presented in the same cycle.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_act;
    logic             vs_act;
    logic             vid_nxt;

    // Pixel enable: last system clock of each pixel period.
    assign pixel_tick = (div_cnt == DIV_LAST);

    // Next-state divider and raster counters.
    always_comb begin
        div_nxt = div_cnt + DIV_W'(1);
        h_nxt   = hcount;
        v_nxt   = vcount;
        h_wrap  = 1'b0;
        v_wrap  = 1'b0;
        if (pixel_tick) begin
            div_nxt = '0;
            if (hcount == H_LAST) begin
                h_nxt  = '0;
                h_wrap = 1'b1;
                if (vcount == V_LAST) begin
                    v_nxt  = '0;
                    v_wrap = 1'b1;
                end else begin
                    v_nxt = vcount + CNT_W'(1);
                end
            end else begin
                h_nxt = hcount + CNT_W'(1);
            end
        end
    end

    // Window decode on the upcoming counter values (registered lookahead).
    always_comb begin
        hs_act  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
        vs_act  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
        vid_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end

    // State and output registers; reset wins over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on    <= vid_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

endmodule
